fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  IF stage: owns the PC, issues instruction fetches to imem over a req/gnt/rvalid
//  handshake, buffers one fetched instruction and presents it to the IF/ID register.
//  Sits directly upstream of IF_ID_reg; stallF is the inverse of IF_ID_regwrite.
//  Redirects (branch/jump from EX) flush the buffer and discard any in-flight response.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC fetched first after reset
//  NOP_INST  32'h0000_0013  InstF value whenever validF=0 (addi x0,x0,0)
// PORTS
//  clk             in   1   clock, rising edge
//  rst             in   1   asynchronous, active-low reset
//  stallF          in   1   1 = IF/ID not accepting; hold buffered instruction
//  redirect_valid  in   1   1 = take redirect_pc this cycle (flush)
//  redirect_pc     in   32  redirect target, word aligned
//  imem_req        out  1   fetch request; held until imem_gnt
//  imem_addr       out  32  fetch address, stable while imem_req && !imem_gnt
//  imem_gnt        in   1   request accepted this cycle
//  imem_rvalid     in   1   response data valid (>=1 cycle after gnt)
//  imem_rdata      in   32  instruction word
//  InstF           out  32  buffered instruction (NOP_INST when !validF)
//  pcF             out  32  address of InstF
//  pc4F            out  32  pcF + 4
//  validF          out  1   buffer holds a valid instruction
// BEHAVIOUR
//  - Reset (rst=0): state=IDLE, pc=RESET_PC, validF=0, InstF=NOP_INST, pcF=0,
//    drop=0, imem_req=0. Async assert, release synchronous to clk.
//  - States IDLE, REQ, WAIT. At most one outstanding fetch.
//  - IDLE: imem_req=0; next cycle -> REQ (first request 1 cycle after reset release).
//  - consume = validF && !stallF. can_issue = !validF || consume.
//  - REQ: imem_req = can_issue, imem_addr = pc. On imem_req && imem_gnt: pc_if <= pc,
//    pc <= pc+4, -> WAIT. Buffer is therefore always empty when a response returns.
//  - WAIT: imem_req=0. On imem_rvalid: if drop or redirect_valid -> discard, drop<=0;
//    else InstF<=imem_rdata, pcF<=pc_if, validF<=1. Either way -> REQ.
//  - consume without new fill: validF<=0, InstF<=NOP_INST.
//  - redirect_valid (any state, priority over stall and fill): pc<=redirect_pc,
//    validF<=0, InstF<=NOP_INST. In WAIT, or in REQ with gnt same cycle: drop<=1 and
//    state=WAIT (stale response still absorbed). In REQ without gnt: stay REQ, new addr.
//  - imem_addr may change only via redirect while ungranted; imem accepts this.
//  - Arithmetic: pc+4 and pc4F are mod 2^32 (0xFFFF_FFFC -> 0x0000_0000).
//  - pc4F combinational from pcF; all other outputs registered except imem_req.
//  - Throughput: zero-wait imem (gnt same cycle, rvalid next) gives 1 instr / 2 cycles.
// STRUCTURE
//  - Shared package: fetch state enum {IDLE,REQ,WAIT}, NOP_INST, XLEN=32.
//  - Single module; no sub-module (PC register + 1-entry buffer + 3-state FSM).
// TESTING
//  1 Reset then imem gnt immediate, rvalid +1: addrs 0x0,0x4,0x8; validF/pcF track;
//    imem_req low exactly 1 cycle after rst release.
//  2 stallF=1 for 5 cycles with validF=1: InstF/pcF held, imem_req=0, no gnt lost.
//  3 redirect_valid to 0x100 while WAIT: response of 0x8 discarded, next addr 0x100,
//    validF=0 until 0x100 data returns.
//  4 redirect_valid coincident with imem_rvalid: data dropped, validF=0, next req 0x100.
//  5 gnt withheld 3 cycles: imem_req/imem_addr stable; redirect mid-wait changes addr.
//  6 rst asserted during WAIT: outputs to reset values immediately; late rvalid
//    after release ignored; fetch restarts at RESET_PC. PC wrap at 0xFFFF_FFFC -> 0x0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
package fetch_pkg;

    localparam int XLEN = 32;

    // Canonical RISC-V NOP (addi x0,x0,0) presented when the buffer is empty.
    localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0013;

    // IDLE: one quiet cycle after reset, REQ: presenting a fetch,
    // WAIT: one fetch granted and its response still outstanding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage.sv
// IF stage: PC register, one-entry instruction buffer and a 3-state fetch FSM
// driving an imem req/gnt/rvalid handshake with at most one fetch in flight.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INST = NOP_WORD
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stallF,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] InstF,
    output logic [XLEN-1:0] pcF,
    output logic [XLEN-1:0] pc4F,
    output logic            validF
);

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_if;   // address of the fetch currently in flight
    logic            drop;    // in-flight response belongs to a squashed path
    logic            consume;
    logic            can_issue;
    logic            granted;

    // A new fetch may only go out if its data will land in an empty buffer.
    always_comb begin
        consume   = validF && !stallF;
        can_issue = !validF || consume;
        imem_req  = (state == REQ) && can_issue;
        granted   = imem_req && imem_gnt;
    end

    assign imem_addr = pc;
    assign pc4F      = pcF + 32'd4;

    // Fetch FSM, PC and buffer; a redirect overrides stall and any fill.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            pc_if  <= '0;
            drop   <= 1'b0;
            validF <= 1'b0;
            InstF  <= NOP_INST;
            pcF    <= '0;
        end else if (redirect_valid) begin
            pc     <= redirect_pc;
            validF <= 1'b0;
            InstF  <= NOP_INST;
            unique case (state)
                IDLE: state <= REQ;
                REQ: begin
                    // Granted in the same cycle: its response must be absorbed.
                    if (granted) begin
                        drop  <= 1'b1;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    // A response arriving now is the stale one; otherwise mark it.
                    if (imem_rvalid) begin
                        drop  <= 1'b0;
                        state <= REQ;
                    end else begin
                        drop <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end else begin
            if (consume) begin
                validF <= 1'b0;
                InstF  <= NOP_INST;
            end
            unique case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (granted) begin
                        pc_if <= pc;
                        pc    <= pc + 32'd4;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (drop) begin
                            drop <= 1'b0;
                        end else begin
                            InstF  <= imem_rdata;
                            pcF    <= pc_if;
                            validF <= 1'b1;
                        end
                        state <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a transaction-level model of the fetch
// stream (PC sequence, in-flight fetches, one-entry buffer) against the DUT.
module tb_fetch_stage;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] RPC  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stallF = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] InstF;
    logic [31:0] pcF;
    logic [31:0] pc4F;
    logic        validF;

    fetch_stage #(.RESET_PC(RPC), .NOP_INST(NOP)) dut (
        .clk(clk), .rst(rst), .stallF(stallF),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .InstF(InstF), .pcF(pcF), .pc4F(pc4F), .validF(validF)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        drop;
    } pend_t;

    int          checks = 0;
    int          failures = 0;

    // Reference model state
    pend_t       pend[$];
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_inst;
    logic [31:0] m_pcF;
    int          n_fill;

    // Observation logs (DUT values) for directed checks
    logic [31:0] gaddr_log[$];
    logic [31:0] fill_log[$];
    logic        prev_v;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'hC001_D00D;
    endfunction

    task automatic model_reset();
        pend.delete();
        m_pc    = RPC;
        m_valid = 1'b0;
        m_inst  = NOP;
        m_pcF   = '0;
        prev_v  = 1'b0;
    endtask

    // One clock cycle: check registered outputs, drive inputs, play imem
    // (gp/vp = grant / response probability in percent), advance the model.
    task automatic cycle(input logic s, input logic rv, input logic [31:0] rp,
                         input int gp, input int vp);
        logic  g, v, exp_req;
        pend_t h;
        @(negedge clk);
        checks++;
        if (validF !== m_valid) begin
            failures++; $display("FAIL validF got=%b exp=%b t=%0t", validF, m_valid, $time);
        end
        checks++;
        if (InstF !== (m_valid ? m_inst : NOP)) begin
            failures++; $display("FAIL InstF got=%h exp=%h t=%0t", InstF, m_valid ? m_inst : NOP, $time);
        end
        checks++;
        if (pcF !== m_pcF) begin
            failures++; $display("FAIL pcF got=%h exp=%h t=%0t", pcF, m_pcF, $time);
        end
        checks++;
        if (pc4F !== m_pcF + 32'd4) begin
            failures++; $display("FAIL pc4F got=%h exp=%h t=%0t", pc4F, m_pcF + 32'd4, $time);
        end
        if (validF === 1'b1 && !prev_v) fill_log.push_back(pcF);
        prev_v = (validF === 1'b1);

        stallF = s; redirect_valid = rv; redirect_pc = rp;
        v = (pend.size() != 0) && ($urandom_range(99) < vp);
        imem_rvalid = v;
        imem_rdata  = v ? mem_word(pend[0].addr) : $urandom;
        #1;
        // A fetch goes out only with nothing in flight and room in the buffer.
        exp_req = (pend.size() == 0) && (!m_valid || !s);
        checks++;
        if (imem_req !== exp_req) begin
            failures++; $display("FAIL imem_req got=%b exp=%b t=%0t", imem_req, exp_req, $time);
        end
        if (exp_req) begin
            checks++;
            if (imem_addr !== m_pc) begin
                failures++; $display("FAIL imem_addr got=%h exp=%h t=%0t", imem_addr, m_pc, $time);
            end
        end
        g = (imem_req === 1'b1) && ($urandom_range(99) < gp);
        imem_gnt = g;
        if (g) gaddr_log.push_back(imem_addr);

        if (v) h = pend.pop_front();
        if (rv) begin
            m_valid = 1'b0;
            foreach (pend[i]) pend[i].drop = 1'b1;
        end else if (v && !h.drop) begin
            m_valid = 1'b1; m_inst = mem_word(h.addr); m_pcF = h.addr; n_fill++;
        end else if (m_valid && !s) begin
            m_valid = 1'b0;
        end
        if (g) pend.push_back('{addr: m_pc, drop: rv});
        if (rv) m_pc = rp;
        else if (g) m_pc = m_pc + 32'd4;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        stallF = 1'b0; redirect_valid = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
        #1;
        checks++;
        if (validF !== 1'b0 || InstF !== NOP || pcF !== 32'h0 || pc4F !== 32'h4) begin
            failures++; $display("FAIL reset_buf got=%b/%h/%h/%h exp=0/%h/0/4", validF, InstF, pcF, pc4F, NOP);
        end
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== RPC) begin
            failures++; $display("FAIL reset_req got=%b/%h exp=0/%h", imem_req, imem_addr, RPC);
        end
        model_reset();
        repeat (2) @(posedge clk);
    endtask

    // Release on a falling edge; the IDLE cycle must keep imem_req low and
    // ignore any late response that the memory still delivers.
    task automatic release_reset(input logic late_rv);
        @(negedge clk);
        rst = 1'b1;
        imem_rvalid = late_rv; imem_rdata = 32'hDEAD_BEEF; imem_gnt = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            failures++; $display("FAIL idle_req got=%b exp=0", imem_req);
        end
        @(posedge clk);
    endtask

    task automatic reach_wait(input string tag);
        for (int i = 0; i < 12 && pend.size() == 0; i++) cycle(1'b0, 1'b0, '0, 100, 0);
        checks++;
        if (pend.size() == 0) begin
            failures++; $display("FAIL %s_reach_wait got=no_grant exp=grant", tag);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        release_reset(1'b0);
    endtask

    task automatic test_stream();
        gaddr_log.delete(); fill_log.delete();
        repeat (7) cycle(1'b0, 1'b0, '0, 100, 100);
        checks++;
        if (gaddr_log.size() < 3 || gaddr_log[0] !== 32'h0 || gaddr_log[1] !== 32'h4 || gaddr_log[2] !== 32'h8) begin
            failures++; $display("FAIL stream_addrs got=%p exp=0,4,8", gaddr_log);
        end
        checks++;
        if (fill_log.size() < 3 || fill_log[0] !== 32'h0 || fill_log[1] !== 32'h4 || fill_log[2] !== 32'h8) begin
            failures++; $display("FAIL stream_fills got=%p exp=0,4,8", fill_log);
        end
    endtask

    task automatic test_stall();
        logic [31:0] cap_pc, cap_inst;
        int          n0;
        repeat (2) cycle(1'b1, 1'b0, '0, 100, 100);
        cap_pc = pcF; cap_inst = InstF; n0 = gaddr_log.size();
        repeat (5) cycle(1'b1, 1'b0, '0, 100, 100);
        checks++;
        if (validF !== 1'b1 || pcF !== cap_pc || InstF !== cap_inst || gaddr_log.size() != n0) begin
            failures++; $display("FAIL stall_hold got=%b/%h/%h/%0d exp=1/%h/%h/%0d",
                                 validF, pcF, InstF, gaddr_log.size(), cap_pc, cap_inst, n0);
        end
        cycle(1'b0, 1'b0, '0, 100, 100);
        checks++;
        if (gaddr_log.size() != n0 + 1 || gaddr_log[gaddr_log.size()-1] !== cap_pc + 32'd4) begin
            failures++; $display("FAIL stall_resume got=%p exp_last=%h", gaddr_log, cap_pc + 32'd4);
        end
    endtask

    task automatic test_redirect_wait();
        reach_wait("rdw");
        gaddr_log.delete(); fill_log.delete();
        cycle(1'b0, 1'b1, 32'h100, 100, 0);
        cycle(1'b0, 1'b0, '0, 100, 100);
        repeat (6) cycle(1'b0, 1'b0, '0, 100, 100);
        checks++;
        if (gaddr_log.size() == 0 || gaddr_log[0] !== 32'h100) begin
            failures++; $display("FAIL rdw_addr got=%p exp=100", gaddr_log);
        end
        checks++;
        if (fill_log.size() == 0 || fill_log[0] !== 32'h100) begin
            failures++; $display("FAIL rdw_fill got=%p exp=100", fill_log);
        end
    endtask

    task automatic test_redirect_rvalid();
        reach_wait("rdv");
        gaddr_log.delete(); fill_log.delete();
        cycle(1'b0, 1'b1, 32'h100, 100, 100);
        repeat (4) cycle(1'b0, 1'b0, '0, 100, 100);
        checks++;
        if (gaddr_log.size() == 0 || gaddr_log[0] !== 32'h100) begin
            failures++; $display("FAIL rdv_addr got=%p exp=100", gaddr_log);
        end
        checks++;
        if (fill_log.size() == 0 || fill_log[0] !== 32'h100) begin
            failures++; $display("FAIL rdv_fill got=%p exp=100", fill_log);
        end
    endtask

    task automatic test_gnt_withheld();
        logic [31:0] cap;
        repeat (3) cycle(1'b0, 1'b0, '0, 0, 100);
        cap = imem_addr;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, '0, 0, 0);
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== cap) begin
                failures++; $display("FAIL gw_stable got=%b/%h exp=1/%h", imem_req, imem_addr, cap);
            end
        end
        cycle(1'b0, 1'b1, 32'h200, 0, 0);
        cycle(1'b0, 1'b0, '0, 0, 0);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            failures++; $display("FAIL gw_redirect got=%b/%h exp=1/200", imem_req, imem_addr);
        end
        gaddr_log.delete();
        repeat (4) cycle(1'b0, 1'b0, '0, 100, 100);
        checks++;
        if (gaddr_log.size() == 0 || gaddr_log[0] !== 32'h200) begin
            failures++; $display("FAIL gw_grant got=%p exp=200", gaddr_log);
        end
    endtask

    task automatic test_reset_mid_wait();
        reach_wait("rst");
        apply_reset();
        release_reset(1'b1);
        gaddr_log.delete(); fill_log.delete();
        repeat (4) cycle(1'b0, 1'b0, '0, 100, 100);
        checks++;
        if (gaddr_log.size() == 0 || gaddr_log[0] !== RPC || fill_log.size() == 0 || fill_log[0] !== RPC) begin
            failures++; $display("FAIL rst_restart got=%p/%p exp=%h", gaddr_log, fill_log, RPC);
        end
    endtask

    task automatic test_wrap();
        logic seen = 1'b0;
        gaddr_log.delete(); fill_log.delete();
        cycle(1'b0, 1'b1, 32'hFFFF_FFF8, 0, 0);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b0, '0, 100, 100);
            if (validF === 1'b1 && pcF === 32'hFFFF_FFFC) begin
                seen = 1'b1;
                checks++;
                if (pc4F !== 32'h0) begin
                    failures++; $display("FAIL wrap_pc4F got=%h exp=0", pc4F);
                end
            end
        end
        checks++;
        if (gaddr_log.size() < 3 || gaddr_log[0] !== 32'hFFFF_FFF8 || gaddr_log[1] !== 32'hFFFF_FFFC || gaddr_log[2] !== 32'h0) begin
            failures++; $display("FAIL wrap_addrs got=%p exp=fffffff8,fffffffc,0", gaddr_log);
        end
        checks++;
        if (!seen) begin
            failures++; $display("FAIL wrap_fill got=absent exp=pcF_fffffffc");
        end
    endtask

    task automatic test_random();
        int f0 = n_fill;
        for (int i = 0; i < 500; i++) begin
            logic s, rv;
            s  = ($urandom_range(99) < 30);
            rv = ($urandom_range(99) < 6);
            cycle(s, rv, {$urandom_range(32'h3FFF), 2'b00}, 60, 50);
        end
        repeat (10) cycle(1'b0, 1'b0, '0, 100, 100);
        checks++;
        if (n_fill - f0 < 20) begin
            failures++; $display("FAIL rand_progress got=%0d exp>=20", n_fill - f0);
        end
    endtask

    initial begin
        n_fill = 0;
        model_reset();
        test_reset();
        test_stream();
        test_stall();
        test_redirect_wait();
        test_redirect_rvalid();
        test_gnt_withheld();
        test_reset_mid_wait();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
